// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU control and its RV-M sequencer.
// Contents:
//   ALUOP_*      2-bit aluop codes coming from the main decoder
//   ALUCON_*     4-bit ALU operation encodings used by the decode
//   M_*          funct3 codes of the M-extension ops
//   FUNCT7_MEXT  funct7 value that marks an R-type op as an M-extension op
//   md_state_t   state of the multiply/divide sequencer
package alu_pkg;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;  // ld/st/jalr: address add
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [3:0] ALUCON_ADD  = 4'b0000;
    localparam logic [3:0] ALUCON_SUB  = 4'b1000;
    localparam logic [3:0] ALUCON_SLT  = 4'b0010;
    localparam logic [3:0] ALUCON_SLTU = 4'b0011;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_DONE = 2'b11
    } md_state_t;

endpackage

// File: rtl/alu_ctrl_md_if.sv
// Bundle between the ID/EX register (master) and the ALU control block (slave).
// Signals:
//   aluop_i, funct7_i, funct3_i  instruction fields of the op held in EX
//   ex_valid_i                   EX holds a real instruction (not a bubble)
//   flush_i                      kill the instruction in EX
//   op_a_i, op_b_i               rs1 / rs2 values
//   alucon_o                     ALU operation
//   md_sel_o                     result mux picks md_result_o
//   md_result_o                  M-op result, meaningful while md_done_o=1
//   md_done_o                    one-cycle pulse, M-op result valid
//   stall_o                      hold IF/ID/EX while an M-op is in flight
//
// Handshake: ex_valid_i is the valid of the instruction sitting in EX and
// stall_o is the inverted ready. The instruction leaves EX on the first clock
// edge where ex_valid_i=1 and stall_o=0; while stall_o=1 the master must keep
// every *_i field stable. flush_i overrides both and drops the instruction.
interface alu_ctrl_md_if #(
    parameter int XLEN = 32
);
    logic [1:0]      aluop_i;
    logic [6:0]      funct7_i;
    logic [2:0]      funct3_i;
    logic            ex_valid_i;
    logic            flush_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic [3:0]      alucon_o;
    logic            md_sel_o;
    logic [XLEN-1:0] md_result_o;
    logic            md_done_o;
    logic            stall_o;

    modport master (
        output aluop_i, funct7_i, funct3_i, ex_valid_i, flush_i, op_a_i, op_b_i,
        input  alucon_o, md_sel_o, md_result_o, md_done_o, stall_o
    );

    modport slave (
        input  aluop_i, funct7_i, funct3_i, ex_valid_i, flush_i, op_a_i, op_b_i,
        output alucon_o, md_sel_o, md_result_o, md_done_o, stall_o
    );
endinterface

// File: rtl/md_iter_core.sv
// Datapath of the multiply/divide sequencer.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   load        capture operands/mode (accept cycle of an M-op)
//   run         perform one shift-add or shift-subtract step
//   funct3_i    M-op selector, sampled on load
//   op_a_i      rs1 value
//   op_b_i      rs2 value
//   special     op finishes in one cycle (div by zero, overflow, fast mul)
//   last        the step performed this cycle is the final one
//   result      sign-corrected result, held until the next completion
module md_iter_core
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            run,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            special,
    output logic            last,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    // acc: MUL -> {partial product high, multiplier shifting out}
    //      DIV -> {partial remainder, dividend shifting into quotient}
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;   // multiplicand or divisor magnitude
    logic [2:0]        mode_q;
    logic              neg_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   res_q;

    logic              sa, sb, neg_in;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div0, ovf, fast;
    logic [XLEN-1:0]   special_val;
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     r_shift;
    logic [XLEN+1:0]   diff;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt;
    logic              unused_bits;

    // Undo the magnitude trick: negate the full product / quotient / remainder.
    function automatic logic [XLEN-1:0] fix_result(input logic [2*XLEN-1:0] raw,
                                                   input logic [2:0] mode,
                                                   input logic neg);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   v;
        if (!mode[2]) begin
            p = neg ? -raw : raw;
            v = (mode[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        end else begin
            v = mode[1] ? raw[2*XLEN-1:XLEN] : raw[XLEN-1:0];
            v = neg ? -v : v;
        end
        return v;
    endfunction

    always_comb begin
        sa = op_a_i[XLEN-1] & ((funct3_i == M_MUL) | (funct3_i == M_MULH) |
                               (funct3_i == M_MULHSU) | (funct3_i == M_DIV) |
                               (funct3_i == M_REM));
        sb = op_b_i[XLEN-1] & ((funct3_i == M_MUL) | (funct3_i == M_MULH) |
                               (funct3_i == M_DIV) | (funct3_i == M_REM));
        case (funct3_i)
            M_MULHSU, M_REM:        neg_in = sa;
            M_MULHU, M_DIVU, M_REMU: neg_in = 1'b0;
            default:                neg_in = sa ^ sb;
        endcase
        mag_a = sa ? -op_a_i : op_a_i;
        mag_b = sb ? -op_b_i : op_b_i;

        div0 = funct3_i[2] & (op_b_i == '0);
        ovf  = ((funct3_i == M_DIV) | (funct3_i == M_REM)) &
               (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (op_b_i == '1);
        fast = FAST_MUL & ~funct3_i[2];
        special = div0 | ovf | fast;

        fast_prod = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
        if (div0)
            special_val = funct3_i[1] ? op_a_i : '1;
        else if (ovf)
            special_val = funct3_i[1] ? '0 : op_a_i;
        else
            special_val = fix_result(fast_prod, funct3_i, neg_in);
    end

    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring step: the partial remainder stays below the divisor, so
        // the shifted value fits XLEN+1 bits and the borrow is the top bit.
        r_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff    = {1'b0, r_shift} - {2'b00, opnd_q};
        if (diff[XLEN+1])
            div_nxt = {r_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            div_nxt = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

        acc_nxt = mode_q[2] ? div_nxt : mul_nxt;
        last    = (cnt_q == CW'(1));
    end

    assign unused_bits = diff[XLEN];
    assign result      = res_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
            mode_q <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            res_q  <= '0;
        end else if (load) begin
            mode_q <= funct3_i;
            neg_q  <= neg_in;
            cnt_q  <= CW'(XLEN);
            acc_q  <= {{XLEN{1'b0}}, (funct3_i[2] ? mag_a : mag_b)};
            opnd_q <= funct3_i[2] ? mag_b : mag_a;
            if (special)
                res_q <= special_val;
        end else if (run) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q - CW'(1);
            if (last)
                res_q <= fix_result(acc_nxt, mode_q, neg_q);
        end
    end
endmodule

// File: rtl/alu_ctrl_md.sv
// EX-stage ALU control with an RV-M multiply/divide sequencer.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   bus        alu_ctrl_md_if.slave: instruction fields, operands, alucon,
//              md_sel/md_result/md_done and stall towards the hazard unit
//   dbg_state  current sequencer state
// The ALU decode is purely combinational; the sequencer accepts an M-op in
// IDLE, iterates XLEN cycles (or finishes at once for the special cases) and
// pulses md_done_o in DONE, the only state where a finished M-op leaves EX.
module alu_ctrl_md
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    alu_ctrl_md_if.slave bus,
    output md_state_t    dbg_state
);
    md_state_t state_q, state_d;
    logic      md_op, accept, run, last, special;
    logic [3:0] alucon;

    always_comb begin
        alucon = ALUCON_ADD;
        case (bus.aluop_i)
            ALUOP_RTYPE:  alucon = {bus.funct7_i[5], bus.funct3_i};
            ALUOP_ITYPE:  alucon = {(bus.funct3_i == 3'b101) & bus.funct7_i[5], bus.funct3_i};
            ALUOP_BRANCH: begin
                case (bus.funct3_i)
                    3'b000, 3'b001: alucon = ALUCON_SUB;
                    3'b100, 3'b101: alucon = ALUCON_SLT;
                    3'b110, 3'b111: alucon = ALUCON_SLTU;
                    default:        alucon = ALUCON_ADD;
                endcase
            end
            default:      alucon = ALUCON_ADD;
        endcase
    end

    // Reset masks md_op so that every output is quiet while rst is held.
    assign md_op  = ~rst & bus.ex_valid_i & (bus.aluop_i == ALUOP_RTYPE) &
                    (bus.funct7_i == FUNCT7_MEXT);
    assign accept = (state_q == MD_IDLE) & md_op & ~bus.flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= MD_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    if (special)
                        state_d = MD_DONE;
                    else
                        state_d = bus.funct3_i[2] ? MD_DIV : MD_MUL;
                end
            end
            MD_MUL, MD_DIV: begin
                if (bus.flush_i)
                    state_d = MD_IDLE;
                else if (last)
                    state_d = MD_DONE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Stall drops combinationally on flush so the hazard unit can redirect
    // in the same cycle.
    always_comb begin
        run         = ((state_q == MD_MUL) | (state_q == MD_DIV)) & ~bus.flush_i;
        bus.stall_o = accept | run;
        bus.md_done_o = (state_q == MD_DONE);
    end

    md_iter_core #(
        .XLEN     (XLEN),
        .FAST_MUL (FAST_MUL)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .run      (run),
        .funct3_i (bus.funct3_i),
        .op_a_i   (bus.op_a_i),
        .op_b_i   (bus.op_b_i),
        .special  (special),
        .last     (last),
        .result   (bus.md_result_o)
    );

    assign bus.alucon_o = alucon;
    assign bus.md_sel_o = md_op;
    assign dbg_state    = state_q;
endmodule
